// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: size codes,
// FSM state encoding, data-memory address width and lane helpers.
package mem_access_unit_pkg;

    localparam int DM_ADDR_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte lane actually used: halves only honour addr[1], words start at lane 0.
    function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            SIZE_WORD: return 2'b00;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage initiator (master)
// and the data memory (slave).
interface mem_access_unit_if;

    logic                                   mem_req;
    logic                                   mem_we;
    logic [mem_access_unit_pkg::DM_ADDR_W-1:0] mem_addr;
    logic [3:0]                             mem_be;
    logic [31:0]                            mem_wdata;
    logic                                   mem_ack;
    logic [31:0]                            mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store data/byte-enable generation and
// load data extraction with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [1:0]  st_lane;
    logic [1:0]  ld_lane;
    logic [31:0] ld_shifted;

    assign st_lane    = lane_offset(st_size, st_addr_lo);
    assign ld_lane    = lane_offset(ld_size, ld_addr_lo);
    assign ld_shifted = ld_rdata >> {ld_lane, 3'b000};

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SIZE_BYTE: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_result = ld_shifted;
        case (ld_size)
            SIZE_BYTE: ld_result = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: ld_result = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
            default:   ld_result = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one op at a time, held request until ack,
// ack timeout abort. Define MEM_ALIGN_CHECK_EN to reject misaligned half/word ops.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    input  logic                   op_load,
    input  logic                   op_store,
    input  logic [1:0]             op_size,
    input  logic                   op_unsigned,
    input  logic [DM_ADDR_W-1:0]   op_addr,
    input  logic [31:0]            op_wdata,
    output logic                   stall,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            ld_data,
    mem_access_unit_if.master      mem
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t                 state;
    logic [TO_W-1:0]        to_cnt;
    logic                   accept;
    logic [1:0]             size_q;
    logic [1:0]             addr_lo_q;
    logic                   uns_q;
    logic                   req_q;
    logic                   we_q;
    logic [DM_ADDR_W-1:0]   addr_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;
    logic [3:0]             st_be;
    logic [31:0]            st_wdata;
    logic [31:0]            ld_result;

    assign accept = op_valid && (op_load || op_store);
    assign stall  = ((state == ST_IDLE) && accept) || (state == ST_BUSY);

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    mem_lane_align u_lane_align (
        .st_size     (op_size),
        .st_addr_lo  (op_addr[1:0]),
        .st_data     (op_wdata),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_addr_lo  (addr_lo_q),
        .ld_rdata    (mem.mem_rdata),
        .ld_result   (ld_result)
    );

    // Request fields are captured once at accept so they stay frozen while mem_req is up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            size_q    <= SIZE_BYTE;
            addr_lo_q <= 2'b00;
            uns_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ld_data   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_q    <= op_size;
                        addr_lo_q <= op_addr[1:0];
                        uns_q     <= op_unsigned;
                        we_q      <= !op_load;
                        addr_q    <= {op_addr[DM_ADDR_W-1:2], 2'b00};
                        be_q      <= st_be;
                        wdata_q   <= st_wdata;
                        to_cnt    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                        if (is_misaligned(op_size, op_addr[1:0])) begin
                            state <= ST_RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else
`endif
                        begin
                            state <= ST_BUSY;
                            req_q <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem.mem_ack) begin
                        req_q  <= 1'b0;
                        state  <= ST_RESP;
                        done   <= 1'b1;
                        err    <= 1'b0;
                        to_cnt <= '0;
                        if (!we_q) begin
                            ld_data <= ld_result;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LIMIT)) begin
                        req_q  <= 1'b0;
                        state  <= ST_RESP;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected requests
// and responses; a negedge monitor compares whatever the DUT presents.
module tb_mem_access_unit;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] ld;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_valid_to = 1'b0;
    logic        op_load = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  op_size = 2'd0;
    logic        op_unsigned = 1'b0;
    logic [31:0] op_addr = '0;
    logic [31:0] op_wdata = '0;
    logic        stall, done, err;
    logic [31:0] ld_data;
    logic        stall_to, done_to, err_to;
    logic [31:0] ld_data_to;

    int n_vec = 0;
    int n_fail = 0;

    req_t req_q[$];
    rsp_t rsp_q[$];
    rsp_t mon_rsp;

    mem_access_unit_if mem_bus ();
    mem_access_unit_if to_bus ();

    mem_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_load     (op_load),
        .op_store    (op_store),
        .op_size     (op_size),
        .op_unsigned (op_unsigned),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .stall       (stall),
        .done        (done),
        .err         (err),
        .ld_data     (ld_data),
        .mem         (mem_bus)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut_to (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid_to),
        .op_load     (op_load),
        .op_store    (op_store),
        .op_size     (op_size),
        .op_unsigned (op_unsigned),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .stall       (stall_to),
        .done        (done_to),
        .err         (err_to),
        .ld_data     (ld_data_to),
        .mem         (to_bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: request fields every cycle mem_req is up, response on each done pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_bus.mem_req) begin
                if (req_q.size() == 0) begin
                    check_output("req_unexpected", {31'b0, mem_bus.mem_req}, 32'd0);
                end else begin
                    check_output("req_we",    {31'b0, mem_bus.mem_we}, {31'b0, req_q[0].we});
                    check_output("req_addr",  mem_bus.mem_addr, req_q[0].addr);
                    check_output("req_be",    {28'b0, mem_bus.mem_be}, {28'b0, req_q[0].be});
                    check_output("req_wdata", mem_bus.mem_wdata, req_q[0].wdata);
                    if (mem_bus.mem_ack) void'(req_q.pop_front());
                end
            end
            if (done) begin
                if (rsp_q.size() == 0) begin
                    check_output("done_unexpected", {31'b0, done}, 32'd0);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check_output("rsp_err",     {31'b0, err}, {31'b0, mon_rsp.err});
                    check_output("rsp_ld_data", ld_data, mon_rsp.ld);
                end
            end
        end
    end

    task automatic apply_stimulus(
        input string       tag,
        input logic        ld,
        input logic        st,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          ack_delay,
        input logic [31:0] rdata,
        input logic        issue_req,
        input req_t        er,
        input rsp_t        ers
    );
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = ld; op_store = st; op_size = sz;
        op_unsigned = uns; op_addr = addr; op_wdata = wdata;
        if (issue_req) req_q.push_back(er);
        rsp_q.push_back(ers);
        #3;
        check_output({tag, "_stall_accept"}, {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        if (issue_req) begin
            for (int i = 0; i < ack_delay; i++) begin
                check_output({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
                @(posedge clk); #1;
            end
            check_output({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
            mem_bus.mem_ack = 1'b1;
            mem_bus.mem_rdata = rdata;
            @(posedge clk); #1;
            mem_bus.mem_ack = 1'b0;
            mem_bus.mem_rdata = '0;
        end
        check_output({tag, "_done"},       {31'b0, done},  32'd1);
        check_output({tag, "_stall_resp"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check_output({tag, "_done_pulse"}, {31'b0, done},  32'd0);
    endtask

    initial begin
        int lat;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        to_bus.mem_ack = 1'b0;
        to_bus.mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_req",   {31'b0, mem_bus.mem_req}, 32'd0);
        check_output("rst_we",    {31'b0, mem_bus.mem_we},  32'd0);
        check_output("rst_addr",  mem_bus.mem_addr,         32'd0);
        check_output("rst_be",    {28'b0, mem_bus.mem_be},  32'd0);
        check_output("rst_wdata", mem_bus.mem_wdata,        32'd0);
        check_output("rst_done",  {31'b0, done},            32'd0);
        check_output("rst_err",   {31'b0, err},             32'd0);
        check_output("rst_ld",    ld_data,                  32'd0);
        check_output("rst_stall", {31'b0, stall},           32'd0);
        reset = 1'b1;

        apply_stimulus("sw10", 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1,
                       '{we:1'b1, addr:32'h10, be:4'b1111, wdata:32'hDEADBEEF}, '{err:1'b0, ld:32'h0});
        apply_stimulus("sb13", 0, 1, 2'd0, 0, 32'h13, 32'h000000AB, 0, 32'h0, 1,
                       '{we:1'b1, addr:32'h10, be:4'b1000, wdata:32'hABABABAB}, '{err:1'b0, ld:32'h0});
        apply_stimulus("sh12", 0, 1, 2'd1, 0, 32'h12, 32'h00001234, 0, 32'h0, 1,
                       '{we:1'b1, addr:32'h10, be:4'b1100, wdata:32'h12341234}, '{err:1'b0, ld:32'h0});
        apply_stimulus("sz3_08", 0, 1, 2'd3, 0, 32'h08, 32'h01020304, 1, 32'h0, 1,
                       '{we:1'b1, addr:32'h08, be:4'b1111, wdata:32'h01020304}, '{err:1'b0, ld:32'h0});
        apply_stimulus("lb21", 1, 0, 2'd0, 0, 32'h21, 32'h0, 0, 32'h00008000, 1,
                       '{we:1'b0, addr:32'h20, be:4'b0010, wdata:32'h0}, '{err:1'b0, ld:32'hFFFFFF80});
        apply_stimulus("lbu21", 1, 0, 2'd0, 1, 32'h21, 32'h0, 0, 32'h00008000, 1,
                       '{we:1'b0, addr:32'h20, be:4'b0010, wdata:32'h0}, '{err:1'b0, ld:32'h00000080});
        apply_stimulus("lh22", 1, 0, 2'd1, 0, 32'h22, 32'h0, 0, 32'h80010000, 1,
                       '{we:1'b0, addr:32'h20, be:4'b1100, wdata:32'h0}, '{err:1'b0, ld:32'hFFFF8001});
        apply_stimulus("sw44_slow", 0, 1, 2'd2, 0, 32'h44, 32'hCAFEF00D, 5, 32'h0, 1,
                       '{we:1'b1, addr:32'h44, be:4'b1111, wdata:32'hCAFEF00D}, '{err:1'b0, ld:32'hFFFF8001});
        apply_stimulus("lhu06", 1, 0, 2'd1, 1, 32'h06, 32'h0, 2, 32'h80017FFE, 1,
                       '{we:1'b0, addr:32'h04, be:4'b1100, wdata:32'h0}, '{err:1'b0, ld:32'h00008001});
        apply_stimulus("lb03_both", 1, 1, 2'd0, 0, 32'h03, 32'h0, 0, 32'h7F000000, 1,
                       '{we:1'b0, addr:32'h00, be:4'b1000, wdata:32'h0}, '{err:1'b0, ld:32'h0000007F});
`ifdef MEM_ALIGN_CHECK_EN
        apply_stimulus("lw22_mis", 1, 0, 2'd2, 0, 32'h22, 32'h0, 0, 32'h11223344, 0,
                       '{we:1'b0, addr:32'h20, be:4'b1111, wdata:32'h0}, '{err:1'b1, ld:32'h0000007F});
`else
        apply_stimulus("lw22_mis", 1, 0, 2'd2, 0, 32'h22, 32'h0, 0, 32'h11223344, 1,
                       '{we:1'b0, addr:32'h20, be:4'b1111, wdata:32'h0}, '{err:1'b0, ld:32'h11223344});
`endif

        // op with neither load nor store, then a stray ack while idle
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = 1'b0; op_store = 1'b0; op_addr = 32'h50;
        #3;
        check_output("nop_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        check_output("nop_req", {31'b0, mem_bus.mem_req}, 32'd0);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        check_output("stray_ack_done", {31'b0, done}, 32'd0);

        // reset asserted while a load is outstanding
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = 1'b1; op_size = 2'd2; op_unsigned = 1'b0; op_addr = 32'h30;
        req_q.push_back('{we:1'b0, addr:32'h30, be:4'b1111, wdata:32'h0});
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0;
        check_output("busy_req", {31'b0, mem_bus.mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("arst_req",   {31'b0, mem_bus.mem_req}, 32'd0);
        check_output("arst_addr",  mem_bus.mem_addr,         32'd0);
        check_output("arst_be",    {28'b0, mem_bus.mem_be},  32'd0);
        check_output("arst_ld",    ld_data,                  32'd0);
        check_output("arst_stall", {31'b0, stall},           32'd0);
        req_q.delete();
        rsp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        apply_stimulus("lw30_post", 1, 0, 2'd2, 0, 32'h30, 32'h0, 0, 32'hA5A5A5A5, 1,
                       '{we:1'b0, addr:32'h30, be:4'b1111, wdata:32'h0}, '{err:1'b0, ld:32'hA5A5A5A5});

        // timeout instance: ack never arrives, limit 4
        @(posedge clk); #1;
        op_valid_to = 1'b1; op_load = 1'b1; op_size = 2'd2; op_addr = 32'h40;
        @(posedge clk); #1;
        op_valid_to = 1'b0; op_load = 1'b0;
        lat = 1;
        while (!done_to && lat < 20) begin
            if (lat == 5) check_output("to_req_held", {31'b0, to_bus.mem_req}, 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        check_output("to_latency", lat,                     32'd6);
        check_output("to_done",    {31'b0, done_to},        32'd1);
        check_output("to_err",     {31'b0, err_to},         32'd1);
        check_output("to_req",     {31'b0, to_bus.mem_req}, 32'd0);
        check_output("to_ld",      ld_data_to,              32'd0);

        repeat (3) @(posedge clk);
        #1;
        check_output("req_drain", req_q.size(), 32'd0);
        check_output("rsp_drain", rsp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
